// File: rtl/ps2_tx_pkg.sv
// PS/2 host transmitter shared types and constants.
// Imported by the host transmitter top and its line filter.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam int FRAME_FALLS = 11;
    localparam int BIT_IDX_W   = 4;
    localparam int TOUT_W      = 16;

    // PS/2 frames carry odd parity over data + parity bit.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the host logic and the PS/2 transmitter.
// master: tx_data/tx_start out, busy/done/err in; slave is the reverse.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, stability filter, fall pulse.
// Ports: clk, reset, raw (async in), level (filtered), fall (1-cycle 1->0 pulse).
module ps2_line_filter
    import ps2_tx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W =
        (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered
    // level; the level flips on the FILTER_LEN-th one.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame.
// Ports: clk, reset, bus (tx_data/tx_start/busy/done/err), ps2 line ins, pull-low enables.
module ps2_host_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 400,
    parameter int unsigned TIMEOUT_CYCLES = 60000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam logic [TOUT_W-1:0] INH_LAST =
        TOUT_W'(INHIBIT_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LIMIT =
        TOUT_W'(TIMEOUT_CYCLES);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST =
        BIT_IDX_W'(FRAME_FALLS - 3);

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    ps2_tx_state_e        state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic                 par_q, par_d;
    logic [BIT_IDX_W-1:0] falls_q, falls_d;
    logic [TOUT_W-1:0]    tout_q, tout_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [TOUT_W-1:0] tout_inc;
    logic              active;
    logic              idle_lines;
    logic              abort;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        falls_d   = falls_q;
        tout_d    = tout_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        // Saturating: a stuck counter must still read as timed out.
        tout_inc   = (tout_q == '1) ? tout_q : tout_q + TOUT_W'(1);
        active     = state_q inside {REQ, DATA, STOP, ACK, WAIT_IDLE};
        idle_lines = clk_level && data_level;

        // The timeout counter is shared with the inhibit phase, so it
        // only follows clk_fall once the device owns the clock.
        if (active) begin
            tout_d = clk_fall ? '0 : tout_inc;
        end

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_start) begin
                    data_d   = bus.tx_data;
                    par_d    = odd_parity(bus.tx_data);
                    falls_d  = '0;
                    tout_d   = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                if (tout_q == INH_LAST) begin
                    tout_d    = '0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    tout_d = tout_q + TOUT_W'(1);
                end
            end
            REQ: begin
                // First REQ cycle still shows clk_oe=1; release it now.
                clk_oe_d = 1'b0;
                if (clk_fall) begin
                    data_oe_d = ~data_q[0];
                    falls_d   = BIT_IDX_W'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    falls_d = falls_q + BIT_IDX_W'(1);
                    if (falls_q == DATA_LAST) begin
                        data_oe_d = ~par_q;
                        state_d   = STOP;
                    end else begin
                        data_oe_d = ~data_q[falls_q[2:0]];
                    end
                end
            end
            STOP: begin
                if (clk_fall) begin
                    falls_d   = falls_q + BIT_IDX_W'(1);
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    falls_d = falls_q + BIT_IDX_W'(1);
                    err_d   = data_level;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (idle_lines) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clock fall in the same cycle resets the counter instead.
        abort = active && !clk_fall && (tout_q >= TOUT_LIMIT) &&
                !(state_q == WAIT_IDLE && idle_lines);
        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            falls_q   <= '0;
            tout_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            falls_q   <= falls_d;
            tout_q    <= tout_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule
